// File: rtl/alucodes.sv
// ALU function encodings shared by the pico-MIPS control unit and ALU.
// RA/RB pass an operand through; the rest are arithmetic/logic ops.
package alucodes;

    localparam logic [2:0] RA   = 3'd0;
    localparam logic [2:0] RB   = 3'd1;
    localparam logic [2:0] RADD = 3'd2;
    localparam logic [2:0] RSUB = 3'd3;
    localparam logic [2:0] RAND = 3'd4;
    localparam logic [2:0] ROR  = 3'd5;
    localparam logic [2:0] RXOR = 3'd6;
    localparam logic [2:0] RMLT = 3'd7;

endpackage

// File: rtl/pico_pkg.sv
// Shared types for the pico-MIPS control unit: opcodes, FSM states,
// operand-B selects, instruction field offsets and decode bundle.
package pico_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_MUL  = 4'h6,
        OP_ADDI = 4'h7,
        OP_MULI = 4'h8,
        OP_LDI  = 4'h9,
        OP_MOV  = 4'hA,
        OP_BEQ  = 4'hB,
        OP_BNE  = 4'hC,
        OP_JMP  = 4'hD,
        OP_INP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALTED
    } state_e;

    localparam logic [1:0] B_REG = 2'b00;
    localparam logic [1:0] B_IMM = 2'b01;
    localparam logic [1:0] B_SW  = 2'b10;

    localparam int OP_LSB  = 14;
    localparam int RD_LSB  = 11;
    localparam int RS_LSB  = 8;
    localparam int IMM_LSB = 0;

    typedef struct packed {
        logic [2:0] func;
        logic [1:0] b_sel;
        logic       writes;
        logic       is_branch;
        logic       branch_on_zero;
        logic       is_jump;
        logic       is_halt;
    } dec_t;

endpackage

// File: rtl/pico_decode.sv
// Combinational opcode decoder: maps the IR opcode onto ALU function,
// operand-B select and the control flags the sequencer needs.
module pico_decode
    import pico_pkg::*;
    import alucodes::*;
(
    input  opcode_e opcode,
    output dec_t    dec
);

    // Opcode table; unlisted fields keep the NOP-like defaults
    always_comb begin
        dec       = '0;
        dec.func  = RA;
        dec.b_sel = B_REG;
        unique case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                dec.func   = RADD;
                dec.writes = 1'b1;
            end
            OP_SUB: begin
                dec.func   = RSUB;
                dec.writes = 1'b1;
            end
            OP_AND: begin
                dec.func   = RAND;
                dec.writes = 1'b1;
            end
            OP_OR: begin
                dec.func   = ROR;
                dec.writes = 1'b1;
            end
            OP_XOR: begin
                dec.func   = RXOR;
                dec.writes = 1'b1;
            end
            OP_MUL: begin
                dec.func   = RMLT;
                dec.writes = 1'b1;
            end
            OP_ADDI: begin
                dec.func   = RADD;
                dec.b_sel  = B_IMM;
                dec.writes = 1'b1;
            end
            OP_MULI: begin
                dec.func   = RMLT;
                dec.b_sel  = B_IMM;
                dec.writes = 1'b1;
            end
            OP_LDI: begin
                dec.func   = RB;
                dec.b_sel  = B_IMM;
                dec.writes = 1'b1;
            end
            OP_MOV: begin
                dec.func   = RB;
                dec.writes = 1'b1;
            end
            OP_BEQ: begin
                dec.func           = RSUB;
                dec.is_branch      = 1'b1;
                dec.branch_on_zero = 1'b1;
            end
            OP_BNE: begin
                dec.func      = RSUB;
                dec.is_branch = 1'b1;
            end
            OP_JMP: begin
                dec.is_jump = 1'b1;
            end
            OP_INP: begin
                dec.func   = RB;
                dec.b_sel  = B_SW;
                dec.writes = 1'b1;
            end
            OP_HALT: begin
                dec.is_halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pico_ctrl.sv
// Multi-cycle pico-MIPS control unit: PC, instruction register and the
// FETCH/DECODE/EXEC/WB sequencer; decode outputs come from IR only.
module pico_ctrl
    import pico_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 8,
    parameter int IW = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run_i,
    input  logic [IW-1:0] instr_i,
    input  logic          alu_zf_i,
    output logic [PW-1:0] pc_o,
    output logic [2:0]    alu_func_o,
    output logic [2:0]    ra_addr_o,
    output logic [2:0]    rb_addr_o,
    output logic [N-1:0]  imm_o,
    output logic [1:0]    b_sel_o,
    output logic          reg_we_o,
    output logic          halted_o
);

    state_e        state;
    state_e        state_nx;
    logic [PW-1:0] pc;
    logic [PW-1:0] pc_nx;
    logic [PW-1:0] pc_inc;
    logic [PW-1:0] target;
    logic [IW-1:0] ir;
    logic [IW-1:0] ir_nx;
    dec_t          dec;

    pico_decode u_decode (
        .opcode (opcode_e'(ir[OP_LSB +: 4])),
        .dec    (dec)
    );

    assign imm_o     = ir[IMM_LSB +: N];
    assign ra_addr_o = ir[RD_LSB +: 3];
    assign rb_addr_o = ir[RS_LSB +: 3];
    assign pc_inc    = pc + PW'(1);
    assign target    = PW'(imm_o);

    // State, PC and IR registers; reset abandons any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
        end
    end

    // Sequencer: next state, PC update and IR load
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        unique case (state)
            FETCH: begin
                if (run_i) state_nx = DECODE;
            end
            DECODE: begin
                ir_nx    = instr_i;
                state_nx = EXEC;
            end
            EXEC: begin
                state_nx = FETCH;
                unique case (1'b1)
                    dec.writes:
                        state_nx = WB;
                    dec.is_branch:
                        pc_nx = (alu_zf_i == dec.branch_on_zero)
                              ? target : pc_inc;
                    dec.is_jump:
                        pc_nx = target;
                    dec.is_halt:
                        state_nx = HALTED;
                    default:
                        pc_nx = pc_inc;
                endcase
            end
            WB: begin
                pc_nx    = pc_inc;
                state_nx = FETCH;
            end
            HALTED: ;
            default: state_nx = FETCH;
        endcase
    end

    assign pc_o       = pc;
    assign alu_func_o = dec.func;
    assign b_sel_o    = dec.b_sel;
    assign reg_we_o   = (state == WB);
    assign halted_o   = (state == HALTED);

endmodule

// File: tb/tb_pico_ctrl.sv
// Self-checking bench for pico_ctrl: opcode table sweep, randomized
// programs against an instruction-level model, and directed corners.
module tb_pico_ctrl;

    localparam logic [2:0] F_RA   = 3'd0;
    localparam logic [2:0] F_RB   = 3'd1;
    localparam logic [2:0] F_RADD = 3'd2;
    localparam logic [2:0] F_RSUB = 3'd3;
    localparam logic [2:0] F_RAND = 3'd4;
    localparam logic [2:0] F_ROR  = 3'd5;
    localparam logic [2:0] F_RXOR = 3'd6;
    localparam logic [2:0] F_RMLT = 3'd7;

    typedef struct {
        logic [3:0] op;
        logic [2:0] func;
        logic [1:0] bsel;
        logic       bcare;
        logic       wr;
    } vec_t;

    vec_t tab [16];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_i = 1'b0;
    logic [17:0] instr_i = '0;
    logic        alu_zf_i = 1'b0;
    logic [7:0]  pc_o;
    logic [2:0]  alu_func_o;
    logic [2:0]  ra_addr_o;
    logic [2:0]  rb_addr_o;
    logic [7:0]  imm_o;
    logic [1:0]  b_sel_o;
    logic        reg_we_o;
    logic        halted_o;

    logic [17:0] rom [256];
    logic [7:0]  mpc;
    logic [17:0] prev_ins;
    int          n_chk = 0;
    int          n_fail = 0;

    pico_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .run_i      (run_i),
        .instr_i    (instr_i),
        .alu_zf_i   (alu_zf_i),
        .pc_o       (pc_o),
        .alu_func_o (alu_func_o),
        .ra_addr_o  (ra_addr_o),
        .rb_addr_o  (rb_addr_o),
        .imm_o      (imm_o),
        .b_sel_o    (b_sel_o),
        .reg_we_o   (reg_we_o),
        .halted_o   (halted_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr_i <= rom[pc_o];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] mk(input logic [3:0] op,
                                       input logic [2:0] rd,
                                       input logic [2:0] rs,
                                       input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [7:0] model_npc(input logic [7:0] pc,
                                             input logic [3:0] op,
                                             input logic [7:0] imm,
                                             input logic zf);
        logic [7:0] seq;
        seq = pc + 8'd1;
        case (op)
            4'hB:    return zf ? imm : seq;
            4'hC:    return zf ? seq : imm;
            4'hD:    return imm;
            4'hF:    return pc;
            default: return seq;
        endcase
    endfunction

    task automatic dec_chk(input string tag, input logic [17:0] ins);
        vec_t v;
        v = tab[ins[17:14]];
        chk({tag, "_func"}, alu_func_o, v.func);
        if (v.bcare) chk({tag, "_bsel"}, b_sel_o, v.bsel);
        chk({tag, "_ra"}, ra_addr_o, ins[13:11]);
        chk({tag, "_rb"}, rb_addr_o, ins[10:8]);
        chk({tag, "_imm"}, imm_o, ins[7:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_pc", pc_o, 0);
        chk("rst_we", reg_we_o, 0);
        chk("rst_halt", halted_o, 0);
        chk("rst_func", alu_func_o, F_RA);
        chk("rst_bsel", b_sel_o, 0);
        @(negedge clk);
        reset = 1'b0;
        mpc = 8'd0;
        prev_ins = '0;
    endtask

    // Runs one instruction from FETCH, checking every cycle against the model
    task automatic exec_one(input logic [17:0] ins, input logic zf,
                            input int stall);
        logic [3:0] op;
        logic [7:0] npc;
        op = ins[17:14];
        rom[mpc] = ins;
        run_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_pc", pc_o, mpc);
            chk("stall_we", reg_we_o, 0);
            chk("stall_halt", halted_o, 0);
            chk("stall_func", alu_func_o, tab[prev_ins[17:14]].func);
            chk("stall_imm", imm_o, prev_ins[7:0]);
        end
        run_i = 1'b1;
        chk("fetch_pc", pc_o, mpc);
        @(posedge clk);
        #1 run_i = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("dec_we", reg_we_o, 0);
        chk("dec_pc", pc_o, mpc);
        @(posedge clk);
        @(negedge clk);
        dec_chk("exec", ins);
        chk("exec_we", reg_we_o, 0);
        chk("exec_pc", pc_o, mpc);
        chk("exec_halt", halted_o, 0);
        alu_zf_i = zf;
        @(posedge clk);
        @(negedge clk);
        if (tab[op].wr) begin
            alu_zf_i = ~zf;
            chk("wb_we", reg_we_o, 1);
            chk("wb_pc", pc_o, mpc);
            dec_chk("wb", ins);
            @(posedge clk);
            @(negedge clk);
        end
        npc = model_npc(mpc, op, ins[7:0], zf);
        if (op == 4'hF) begin
            chk("halt_flag", halted_o, 1);
        end else begin
            chk("done_halt", halted_o, 0);
        end
        chk("next_pc", pc_o, npc);
        chk("done_we", reg_we_o, 0);
        mpc = npc;
        prev_ins = ins;
    endtask

    initial begin
        tab[0]  = '{4'h0, F_RA,   2'b00, 1'b1, 1'b0};
        tab[1]  = '{4'h1, F_RADD, 2'b00, 1'b1, 1'b1};
        tab[2]  = '{4'h2, F_RSUB, 2'b00, 1'b1, 1'b1};
        tab[3]  = '{4'h3, F_RAND, 2'b00, 1'b1, 1'b1};
        tab[4]  = '{4'h4, F_ROR,  2'b00, 1'b1, 1'b1};
        tab[5]  = '{4'h5, F_RXOR, 2'b00, 1'b1, 1'b1};
        tab[6]  = '{4'h6, F_RMLT, 2'b00, 1'b1, 1'b1};
        tab[7]  = '{4'h7, F_RADD, 2'b01, 1'b1, 1'b1};
        tab[8]  = '{4'h8, F_RMLT, 2'b01, 1'b1, 1'b1};
        tab[9]  = '{4'h9, F_RB,   2'b01, 1'b1, 1'b1};
        tab[10] = '{4'hA, F_RB,   2'b00, 1'b1, 1'b1};
        tab[11] = '{4'hB, F_RSUB, 2'b00, 1'b1, 1'b0};
        tab[12] = '{4'hC, F_RSUB, 2'b00, 1'b1, 1'b0};
        tab[13] = '{4'hD, F_RA,   2'b00, 1'b0, 1'b0};
        tab[14] = '{4'hE, F_RB,   2'b10, 1'b1, 1'b1};
        tab[15] = '{4'hF, F_RA,   2'b00, 1'b0, 1'b0};
        for (int i = 0; i < 256; i++) rom[i] = '0;

        #2;
        do_reset();
        exec_one(mk(4'h7, 3'd1, 3'd0, 8'd5), 1'b0, 0);
        chk("addi_pc1", pc_o, 8'd1);

        for (int i = 0; i < 15; i++) begin
            for (int z = 0; z < 2; z++) begin
                exec_one(mk(tab[i].op, 3'(i), 3'(~i), mpc + 8'h20),
                         1'(z), i % 3);
            end
        end

        do_reset();
        exec_one(mk(4'hB, 3'd1, 3'd2, 8'h20), 1'b1, 0);
        chk("beq_taken", pc_o, 8'h20);
        exec_one(mk(4'hB, 3'd1, 3'd2, 8'h50), 1'b0, 0);
        chk("beq_fall", pc_o, 8'h21);
        exec_one(mk(4'hC, 3'd1, 3'd2, 8'h60), 1'b0, 0);
        chk("bne_taken", pc_o, 8'h60);

        exec_one(mk(4'hD, 3'd0, 3'd0, 8'hFF), 1'b0, 0);
        chk("jmp_ff", pc_o, 8'hFF);
        exec_one(mk(4'h0, 3'd0, 3'd0, 8'h00), 1'b0, 0);
        chk("wrap_pc", pc_o, 8'h00);

        exec_one(mk(4'h1, 3'd3, 3'd4, 8'h11), 1'b0, 10);

        for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            exec_one(mk(op, 3'($urandom), 3'($urandom), 8'($urandom)),
                     1'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
        end

        do_reset();
        for (int i = 0; i < 3; i++)
            exec_one(mk(4'h0, 3'd0, 3'd0, 8'h00), 1'($urandom), 0);
        exec_one(mk(4'hF, 3'd0, 3'd0, 8'h00), 1'b0, 0);
        rom[3] = mk(4'h1, 3'd1, 3'd1, 8'h00);
        run_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            alu_zf_i = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("halt_stay", halted_o, 1);
            chk("halt_pc", pc_o, 8'd3);
            chk("halt_we", reg_we_o, 0);
        end

        do_reset();
        for (int i = 0; i < 5; i++)
            exec_one(mk(4'h0, 3'd0, 3'd0, 8'h00), 1'b0, 0);
        rom[5] = mk(4'h6, 3'd3, 3'd4, 8'h00);
        run_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("mul_func", alu_func_o, F_RMLT);
        @(posedge clk);
        @(negedge clk);
        chk("mul_wb_we", reg_we_o, 1);
        chk("mul_wb_pc", pc_o, 8'd5);
        #2 reset = 1'b1;
        #1;
        chk("arst_we", reg_we_o, 0);
        chk("arst_pc", pc_o, 0);
        chk("arst_halt", halted_o, 0);
        do_reset();
        exec_one(mk(4'h2, 3'd5, 3'd6, 8'h33), 1'b0, 0);
        chk("restart_pc", pc_o, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pico_ctrl.md
Name: pico_ctrl

Overview:
- Multi-cycle control unit for the pico-MIPS datapath, directly upstream of the ALU.
- Fetches from a synchronous program ROM, holds the instruction register and PC, and decodes into ALU func, register addresses and operand-B select.
- Sequences FETCH/DECODE/EXEC/WB and resolves branches from the ALU zero flag.
- Register file, operand-B mux and ROM are external.

Parameters:
- N, 8, data width; immediate width.
- PW, 8, PC / ROM address width.
- IW, 18, instruction width. Fields: opcode[17:14], rd[13:11], rs[10:8], imm[7:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- run_i  input  1  allows leaving FETCH; low stalls before the next instruction.
- instr_i  input  IW  ROM data; valid the cycle after pc_o is presented.
- alu_zf_i  input  1  ALU zero flag.
- pc_o  output  PW  ROM address (registered PC).
- alu_func_o  output  3  ALU function code (RA..RMLT encodings).
- ra_addr_o  output  3  register-file read port A address (= rd field).
- rb_addr_o  output  3  register-file read port B address (= rs field).
- imm_o  output  N  immediate field.
- b_sel_o  output  2  operand-B select: 00 reg rs, 01 imm, 10 switch input.
- reg_we_o  output  1  register-file write enable; write address = ra_addr_o.
- halted_o  output  1  high in HALT state.

Behaviour:
- Reset (asynchronous, immediate): state=FETCH, PC=0, IR=0 (NOP), reg_we_o=0, halted_o=0, alu_func_o=RA, b_sel_o=00. Any in-flight instruction is abandoned; no write occurs.
- Decode outputs (alu_func_o, ra/rb_addr_o, imm_o, b_sel_o) are combinational from IR only. They are stable through EXEC and WB, so ALU inputs do not change while the result is consumed.
- FETCH: pc_o drives the ROM. If run_i=1, go to DECODE; otherwise stay. run_i is sampled only in FETCH.
- DECODE: IR <= instr_i; go to EXEC.
- EXEC:
  - ALU-writing ops go to WB.
  - BEQ/BNE: sample alu_zf_i. Taken: PC <= imm[PW-1:0]; else PC <= PC+1. Go to FETCH.
  - JMP: PC <= imm; go to FETCH.
  - NOP: PC+1; go to FETCH.
  - HALT: go to HALTED; PC holds.
- WB: reg_we_o=1 for exactly this cycle; PC <= PC+1; go to FETCH.
- HALTED: halted_o=1, reg_we_o=0, PC frozen; exit only via reset. run_i is ignored.
- Opcode map (opcode: func, b_sel, writes):
  - 0 NOP: –, –, no.
  - 1 ADD: RADD, reg, yes.
  - 2 SUB: RSUB, reg, yes.
  - 3 AND: RAND, reg, yes.
  - 4 OR: ROR, reg, yes.
  - 5 XOR: RXOR, reg, yes.
  - 6 MUL: RMLT, reg, yes.
  - 7 ADDI: RADD, imm, yes.
  - 8 MULI: RMLT, imm, yes.
  - 9 LDI: RB, imm, yes.
  - A MOV: RB, reg, yes.
  - B BEQ: RSUB, reg, no.
  - C BNE: RSUB, reg, no.
  - D JMP: RA, –, no.
  - E INP: RB, sw, yes.
  - F HALT: RA, –, no.
- Latency: write ops take 4 cycles (F,D,E,WB). NOP/branch/JMP take 3 cycles. HALT is terminal.
- PC arithmetic is modulo 2^PW: PC+1 wraps from 2^PW-1 to 0. Branch target is imm truncated to PW bits.
- Reads of rd and a write to rd in the same WB cycle are legal; the write lands on the WB clock edge.
- All 16 opcodes are defined; there is no illegal-instruction path.

Decomposition:
- pico_pkg: opcode enum (4 bits), state enum {FETCH, DECODE, EXEC, WB, HALTED}, b_sel localparams, instruction field offsets.
- ALU func encodings are shared from alucodes.sv.
- One sub-module, pico_decode: purely combinational IR -> {alu_func, b_sel, writes, is_branch, branch_on_zero, is_jump, is_halt}.
- FSM and PC stay in pico_ctrl.

Test Plan:
- Reset, ROM[0]=ADDI r1,5 -> pc_o=0; cycle 4: alu_func_o=RADD, b_sel_o=01, imm_o=5, ra_addr_o=1, reg_we_o=1 for one cycle; then pc_o=1.
- BEQ r1,r2,0x20 with alu_zf_i=1 in EXEC -> reg_we_o never asserted, pc_o=0x20 after 3 cycles. With alu_zf_i=0 -> pc_o=PC+1. BNE gives the inverse.
- ROM[0xFF]=NOP reached via JMP 0xFF -> next pc_o=0x00 (wrap).
- run_i=0 held 10 cycles in FETCH -> state, PC and IR unchanged, reg_we_o=0. run_i dropped during EXEC -> instruction still completes, stall occurs at the next FETCH.
- HALT at pc 3 -> halted_o=1 from the cycle after EXEC, pc_o stays 3 for 20 cycles with run_i=1, reg_we_o=0.
- reset asserted mid-WB of MUL (asynchronous) -> reg_we_o falls immediately, pc_o=0, halted_o=0; after release, execution restarts at PC 0.
